estagio_writeback_mem: RTL and testbench
========================================

Name: estagio_writeback_mem

Overview:
Parametrised successor of the single memory/ULA writeback mux. It selects among four writeback sources (ULA result, memory load data, PC+4 link value, immediate) and extracts/extends byte and halfword loads. Its output is registered into the writeback stage with valid, stall and flush control. It also holds off with a ready/valid handshake while a memory load has not yet returned. It sits between the memory-access stage and the register-file write port.

Parameters:
DATA_WIDTH, 32, datapath width in bits; legal values are 32 and 64. Sub-word lanes are taken from the low 32 bits.
REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
entrada_valida  input  1  upstream presents a valid instruction this cycle
pronto  output  1  stage can accept an instruction this cycle (combinational)
stall  input  1  hold all registered state
flush  input  1  discard the in-flight/accepted instruction
sel_fonte  input  2  source select: 00 ULA, 01 MEM, 10 PC+4, 11 IMED
tamanho_load  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_sem_sinal  input  1  1 selects zero-extension, 0 selects sign-extension
endereco_baixo  input  2  low address bits of the load
dado_lido_mem  input  DATA_WIDTH  memory read data
mem_valido  input  1  dado_lido_mem is valid this cycle
resultado_ula  input  DATA_WIDTH  ULA result
pc_mais_4  input  DATA_WIDTH  link value
imediato  input  DATA_WIDTH  upper immediate, already shifted
reg_destino_in  input  REG_ADDR_WIDTH  destination register index
dado_escrita  output  DATA_WIDTH  registered writeback data
reg_destino  output  REG_ADDR_WIDTH  registered destination index
escrita_valida  output  1  registered register-file write enable

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - dado_escrita=0, reg_destino=0, escrita_valida=0.
  - State returns to OCIOSO; internal captured fields are cleared.
- FSM states:
  - OCIOSO: pronto = !stall.
  - ESPERA_MEM: pronto = 0.
- Accept condition: OCIOSO, entrada_valida=1, stall=0, flush=0.
  - sel_fonte != 01, or (sel_fonte=01 and mem_valido=1): register the selected/extracted value and reg_destino_in on the next edge. escrita_valida=1 unless reg_destino_in==0, in which case it is 0. Latency is 1 cycle.
  - sel_fonte=01 and mem_valido=0: capture reg_destino_in, tamanho_load, load_sem_sinal and endereco_baixo; go to ESPERA_MEM; escrita_valida=0 on the next edge.
- No accept in OCIOSO (and stall=0): escrita_valida=0 on the next edge; dado_escrita and reg_destino hold.
- ESPERA_MEM, mem_valido=1, stall=0, flush=0:
  - Register the extracted dado_lido_mem using the captured fields.
  - escrita_valida=1 (0 if the captured destination is 0).
  - Return to OCIOSO.
  - Inputs other than mem_valido/dado_lido_mem are ignored while in ESPERA_MEM.
- Extraction:
  - Byte: lane dado_lido_mem[8*a+7 : 8*a], where a = endereco_baixo.
  - Half: lane [16*endereco_baixo[1]+15 : 16*endereco_baixo[1]]; endereco_baixo[0] is ignored (no misalignment trap).
  - Word: low 32 bits.
  - The result is zero- or sign-extended to DATA_WIDTH per load_sem_sinal.
- Non-MEM sources pass full DATA_WIDTH unchanged.
- stall=1 (and flush=0): every register and the FSM state hold, including escrita_valida. No new capture occurs. mem_valido arriving during a stall is not consumed.
- flush=1:
  - Highest priority after reset.
  - Next edge: escrita_valida=0 and state=OCIOSO; dado_escrita and reg_destino hold.
  - An outstanding ESPERA_MEM load is abandoned.
  - flush overrides a simultaneous stall.
- Simultaneous accept and mem_valido in OCIOSO with sel_fonte=01: no wait state is entered.

Optional Feature:
Macro: ESTAGIO_WB_BYPASS_EN.
- When defined, adds outputs bypass_dado (DATA_WIDTH), bypass_reg (REG_ADDR_WIDTH) and bypass_valido (1). These carry, combinationally, the value/index that will be registered on the next edge. bypass_valido is 1 exactly when the next edge will set escrita_valida=1. This allows decode-stage forwarding without waiting one cycle.
- When undefined, the ports do not exist and no bypass logic is generated.

Test Plan:
- Reset mid-ESPERA_MEM: start a MEM load with mem_valido=0, then reset=1 for 1 cycle. Required: escrita_valida=0, dado_escrita=0, pronto=1 after the edge; a later mem_valido is ignored.
- ULA path: sel=00, resultado_ula=0x12345678, reg_destino_in=7, valid. Required next cycle: dado_escrita=0x12345678, reg_destino=7, escrita_valida=1.
- Signed byte load: sel=01, tamanho=00, load_sem_sinal=0, endereco_baixo=3, dado_lido_mem=0x80FF_0000, mem_valido=1. Required: dado_escrita=0xFFFFFF80.
- Unsigned half with wait: sel=01, tamanho=01, load_sem_sinal=1, endereco_baixo=2, mem_valido=0 for 3 cycles then 1 with data 0xBEEF_1234. Required: pronto=0 during the wait; dado_escrita=0x0000BEEF exactly 1 cycle after mem_valido.
- Stall then flush:
  - Load PC+4=0x104 into rd=1, then stall=1 for 2 cycles. Required: outputs hold at 0x104/1/valid.
  - Then flush=1 together with stall=1. Required: escrita_valida=0 on the next edge.
- x0 discard: sel=11, imediato=0xABCD0000, reg_destino_in=0. Required: escrita_valida=0, dado_escrita=0xABCD0000. With ESTAGIO_WB_BYPASS_EN defined, bypass_valido=0 in the same cycle.

Source files
------------

// File: rtl/estagio_writeback_mem_if.sv
// Bus between the memory-access stage, the writeback stage and the register-file
// write port.
// Optional macro ESTAGIO_WB_BYPASS_EN adds the combinational forwarding signals.
interface estagio_writeback_mem_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      entrada_valida;
    logic                      pronto;
    logic                      stall;
    logic                      flush;
    logic [1:0]                sel_fonte;
    logic [1:0]                tamanho_load;
    logic                      load_sem_sinal;
    logic [1:0]                endereco_baixo;
    logic [DATA_WIDTH-1:0]     dado_lido_mem;
    logic                      mem_valido;
    logic [DATA_WIDTH-1:0]     resultado_ula;
    logic [DATA_WIDTH-1:0]     pc_mais_4;
    logic [DATA_WIDTH-1:0]     imediato;
    logic [REG_ADDR_WIDTH-1:0] reg_destino_in;
    logic [DATA_WIDTH-1:0]     dado_escrita;
    logic [REG_ADDR_WIDTH-1:0] reg_destino;
    logic                      escrita_valida;
`ifdef ESTAGIO_WB_BYPASS_EN
    logic [DATA_WIDTH-1:0]     bypass_dado;
    logic [REG_ADDR_WIDTH-1:0] bypass_reg;
    logic                      bypass_valido;
`endif

    // Upstream / environment side
    modport master (
        output entrada_valida, stall, flush, sel_fonte, tamanho_load, load_sem_sinal,
               endereco_baixo, dado_lido_mem, mem_valido, resultado_ula, pc_mais_4,
               imediato, reg_destino_in,
`ifdef ESTAGIO_WB_BYPASS_EN
        input  bypass_dado, bypass_reg, bypass_valido,
`endif
        input  pronto, dado_escrita, reg_destino, escrita_valida
    );

    // Writeback stage side
    modport slave (
        input  entrada_valida, stall, flush, sel_fonte, tamanho_load, load_sem_sinal,
               endereco_baixo, dado_lido_mem, mem_valido, resultado_ula, pc_mais_4,
               imediato, reg_destino_in,
`ifdef ESTAGIO_WB_BYPASS_EN
        output bypass_dado, bypass_reg, bypass_valido,
`endif
        output pronto, dado_escrita, reg_destino, escrita_valida
    );
endinterface

// File: rtl/estagio_writeback_mem.sv
// Writeback stage: selects ULA / MEM / PC+4 / IMED, extracts and extends sub-word
// loads, and registers the register-file write. A load whose data has not yet
// returned parks the stage in ESPERA_MEM until mem_valido arrives.
// Optional macro ESTAGIO_WB_BYPASS_EN exposes the next-edge write for forwarding.
module estagio_writeback_mem #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    estagio_writeback_mem_if.slave  bus
);
    localparam logic [0:0] OCIOSO     = 1'b0;
    localparam logic [0:0] ESPERA_MEM = 1'b1;

    localparam logic [1:0] SEL_ULA  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    // Picks the byte/half/word lane from the low 32 bits and extends it.
    function automatic logic [DATA_WIDTH-1:0] extrair(
        input logic [DATA_WIDTH-1:0] dado,
        input logic [1:0]            tamanho,
        input logic                  sem_sinal,
        input logic [1:0]            endereco
    );
        logic signed [7:0]  v_byte;
        logic signed [15:0] v_half;
        logic signed [31:0] v_word;
        logic [DATA_WIDTH-1:0] v_res;
        v_word = dado[31:0];
        case (endereco)
            2'd0:    v_byte = v_word[7:0];
            2'd1:    v_byte = v_word[15:8];
            2'd2:    v_byte = v_word[23:16];
            default: v_byte = v_word[31:24];
        endcase
        v_half = endereco[1] ? v_word[31:16] : v_word[15:0];
        case (tamanho)
            2'b00:   v_res = sem_sinal ? DATA_WIDTH'($unsigned(v_byte)) : DATA_WIDTH'(v_byte);
            2'b01:   v_res = sem_sinal ? DATA_WIDTH'($unsigned(v_half)) : DATA_WIDTH'(v_half);
            default: v_res = sem_sinal ? DATA_WIDTH'($unsigned(v_word)) : DATA_WIDTH'(v_word);
        endcase
        return v_res;
    endfunction

    logic [0:0]                r_estado;
    logic [REG_ADDR_WIDTH-1:0] r_rd_cap;
    logic [1:0]                r_tam_cap;
    logic                      r_sem_sinal_cap;
    logic [1:0]                r_end_cap;
    logic [DATA_WIDTH-1:0]     r_dado;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_valida;

    logic                      w_aceita;
    logic                      w_mem_pronta;
    logic                      w_conclui_espera;
    logic                      w_grava;
    logic                      w_inicia_espera;
    logic [DATA_WIDTH-1:0]     w_fonte;
    logic [DATA_WIDTH-1:0]     w_prox_dado;
    logic [REG_ADDR_WIDTH-1:0] w_prox_rd;
    logic                      w_prox_valida;

    assign w_aceita         = (r_estado == OCIOSO) && bus.entrada_valida && !bus.stall && !bus.flush;
    assign w_mem_pronta     = (bus.sel_fonte != SEL_MEM) || bus.mem_valido;
    assign w_conclui_espera = (r_estado == ESPERA_MEM) && bus.mem_valido && !bus.stall && !bus.flush;
    assign w_grava          = (w_aceita && w_mem_pronta) || w_conclui_espera;
    assign w_inicia_espera  = w_aceita && !w_mem_pronta;

    // Source mux for a freshly accepted instruction.
    always_comb begin
        w_fonte = bus.imediato;
        case (bus.sel_fonte)
            SEL_ULA: w_fonte = bus.resultado_ula;
            SEL_MEM: w_fonte = extrair(bus.dado_lido_mem, bus.tamanho_load,
                                       bus.load_sem_sinal, bus.endereco_baixo);
            SEL_PC4: w_fonte = bus.pc_mais_4;
            default: w_fonte = bus.imediato;
        endcase
    end

    // Value and index that the next edge would write; a completing wait uses the captured fields.
    always_comb begin
        w_prox_dado = w_fonte;
        w_prox_rd   = bus.reg_destino_in;
        if (w_conclui_espera) begin
            w_prox_dado = extrair(bus.dado_lido_mem, r_tam_cap, r_sem_sinal_cap, r_end_cap);
            w_prox_rd   = r_rd_cap;
        end
        w_prox_valida = w_grava && (w_prox_rd != '0);
    end

    // State, captured load fields and writeback registers; flush beats stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado        <= OCIOSO;
            r_rd_cap        <= '0;
            r_tam_cap       <= '0;
            r_sem_sinal_cap <= 1'b0;
            r_end_cap       <= '0;
            r_dado          <= '0;
            r_rd            <= '0;
            r_valida        <= 1'b0;
        end else if (bus.flush) begin
            r_estado <= OCIOSO;
            r_valida <= 1'b0;
        end else if (!bus.stall) begin
            r_valida <= w_prox_valida;
            if (w_grava) begin
                r_dado <= w_prox_dado;
                r_rd   <= w_prox_rd;
            end
            if (w_inicia_espera) begin
                r_estado        <= ESPERA_MEM;
                r_rd_cap        <= bus.reg_destino_in;
                r_tam_cap       <= bus.tamanho_load;
                r_sem_sinal_cap <= bus.load_sem_sinal;
                r_end_cap       <= bus.endereco_baixo;
            end else if (w_conclui_espera) begin
                r_estado <= OCIOSO;
            end
        end
    end

    assign bus.pronto         = (r_estado == OCIOSO) && !bus.stall;
    assign bus.dado_escrita   = r_dado;
    assign bus.reg_destino    = r_rd;
    assign bus.escrita_valida = r_valida;

`ifdef ESTAGIO_WB_BYPASS_EN
    assign bus.bypass_dado   = w_prox_dado;
    assign bus.bypass_reg    = w_prox_rd;
    assign bus.bypass_valido = w_prox_valida && !reset;
`endif

endmodule

// File: tb/tb_estagio_writeback_mem.sv
// Self-checking bench for estagio_writeback_mem: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_estagio_writeback_mem;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk;
    logic rst;
    int   chk;
    int   err;

    estagio_writeback_mem_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) bus ();

    estagio_writeback_mem #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference lane extraction from plain shifts and masks.
    function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [1:0] tam,
                                            input logic sem, input logic [1:0] a);
        logic [31:0] lane;
        int bits;
        if (tam == 2'd0) begin
            lane = (d >> (8 * int'(a))) & 32'hFF;
            bits = 8;
        end else if (tam == 2'd1) begin
            lane = (d >> (16 * int'(a[1]))) & 32'hFFFF;
            bits = 16;
        end else begin
            lane = d;
            bits = 32;
        end
        if (!sem && bits < 32 && lane[bits-1])
            lane = lane | ~((32'd1 << bits) - 32'd1);
        return lane;
    endfunction

    task automatic idle_inputs();
        rst                = 1'b0;
        bus.entrada_valida = 1'b0;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.sel_fonte      = 2'b00;
        bus.tamanho_load   = 2'b10;
        bus.load_sem_sinal = 1'b0;
        bus.endereco_baixo = 2'b00;
        bus.dado_lido_mem  = '0;
        bus.mem_valido     = 1'b0;
        bus.resultado_ula  = '0;
        bus.pc_mais_4      = '0;
        bus.imediato       = '0;
        bus.reg_destino_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk++;
        if (bus.escrita_valida !== 1'b0) begin err++; $display("FAIL reset_valida got=%b exp=0", bus.escrita_valida); end
        chk++;
        if (bus.dado_escrita !== 32'h0) begin err++; $display("FAIL reset_dado got=%h exp=0", bus.dado_escrita); end
        chk++;
        if (bus.reg_destino !== 5'd0) begin err++; $display("FAIL reset_rd got=%0d exp=0", bus.reg_destino); end
        chk++;
        if (bus.pronto !== 1'b1) begin err++; $display("FAIL reset_pronto got=%b exp=1", bus.pronto); end
    endtask

    task automatic test_ula();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b00;
        bus.resultado_ula  = 32'h12345678;
        bus.reg_destino_in = 5'd7;
        tick();
        idle_inputs();
        chk++;
        if (bus.dado_escrita !== 32'h12345678) begin err++; $display("FAIL ula_dado got=%h exp=12345678", bus.dado_escrita); end
        chk++;
        if (bus.reg_destino !== 5'd7) begin err++; $display("FAIL ula_rd got=%0d exp=7", bus.reg_destino); end
        chk++;
        if (bus.escrita_valida !== 1'b1) begin err++; $display("FAIL ula_valida got=%b exp=1", bus.escrita_valida); end
        tick();
        chk++;
        if (bus.escrita_valida !== 1'b0 || bus.dado_escrita !== 32'h12345678) begin
            err++; $display("FAIL idle_hold got=%b/%h exp=0/12345678", bus.escrita_valida, bus.dado_escrita);
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b01;
        bus.reg_destino_in = 5'd9;
        tick();
        bus.entrada_valida = 1'b0;
        #1;
        chk++;
        if (bus.pronto !== 1'b0) begin err++; $display("FAIL wait_pronto got=%b exp=0", bus.pronto); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk++;
        if (bus.escrita_valida !== 1'b0 || bus.dado_escrita !== 32'h0 || bus.pronto !== 1'b1) begin
            err++; $display("FAIL rst_mid_wait got=%b/%h/%b exp=0/0/1", bus.escrita_valida, bus.dado_escrita, bus.pronto);
        end
        bus.mem_valido    = 1'b1;
        bus.dado_lido_mem = 32'hCAFEF00D;
        tick();
        idle_inputs();
        chk++;
        if (bus.escrita_valida !== 1'b0 || bus.dado_escrita !== 32'h0) begin
            err++; $display("FAIL stale_mem got=%b/%h exp=0/0", bus.escrita_valida, bus.dado_escrita);
        end
    endtask

    task automatic test_signed_byte();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b01;
        bus.tamanho_load   = 2'b00;
        bus.load_sem_sinal = 1'b0;
        bus.endereco_baixo = 2'd3;
        bus.dado_lido_mem  = 32'h80FF0000;
        bus.mem_valido     = 1'b1;
        bus.reg_destino_in = 5'd3;
        tick();
        idle_inputs();
        chk++;
        if (bus.dado_escrita !== 32'hFFFFFF80 || bus.escrita_valida !== 1'b1) begin
            err++; $display("FAIL sbyte got=%h/%b exp=ffffff80/1", bus.dado_escrita, bus.escrita_valida);
        end
    endtask

    task automatic test_half_wait();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b01;
        bus.tamanho_load   = 2'b01;
        bus.load_sem_sinal = 1'b1;
        bus.endereco_baixo = 2'd2;
        bus.reg_destino_in = 5'd12;
        tick();
        // Garbage on the other inputs must be ignored while waiting.
        bus.tamanho_load   = 2'b00;
        bus.load_sem_sinal = 1'b0;
        bus.endereco_baixo = 2'd0;
        bus.reg_destino_in = 5'd30;
        bus.sel_fonte      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk++;
            if (bus.pronto !== 1'b0 || bus.escrita_valida !== 1'b0) begin
                err++; $display("FAIL half_wait%0d got=%b/%b exp=0/0", i, bus.pronto, bus.escrita_valida);
            end
            tick();
        end
        bus.mem_valido    = 1'b1;
        bus.dado_lido_mem = 32'hBEEF1234;
        tick();
        idle_inputs();
        chk++;
        if (bus.dado_escrita !== 32'h0000BEEF || bus.reg_destino !== 5'd12 || bus.escrita_valida !== 1'b1) begin
            err++; $display("FAIL uhalf got=%h/%0d/%b exp=0000beef/12/1", bus.dado_escrita, bus.reg_destino, bus.escrita_valida);
        end
        #1;
        chk++;
        if (bus.pronto !== 1'b1) begin err++; $display("FAIL uhalf_pronto got=%b exp=1", bus.pronto); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b10;
        bus.pc_mais_4      = 32'h104;
        bus.reg_destino_in = 5'd1;
        tick();
        bus.stall         = 1'b1;
        bus.pc_mais_4     = 32'h999;
        bus.reg_destino_in = 5'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk++;
            if (bus.dado_escrita !== 32'h104 || bus.reg_destino !== 5'd1 || bus.escrita_valida !== 1'b1) begin
                err++; $display("FAIL stall_hold%0d got=%h/%0d/%b exp=104/1/1", i, bus.dado_escrita, bus.reg_destino, bus.escrita_valida);
            end
        end
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        chk++;
        if (bus.escrita_valida !== 1'b0 || bus.dado_escrita !== 32'h104) begin
            err++; $display("FAIL flush_stall got=%b/%h exp=0/104", bus.escrita_valida, bus.dado_escrita);
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        bus.entrada_valida = 1'b1;
        bus.sel_fonte      = 2'b11;
        bus.imediato       = 32'hABCD0000;
        bus.reg_destino_in = 5'd0;
`ifdef ESTAGIO_WB_BYPASS_EN
        #1;
        chk++;
        if (bus.bypass_valido !== 1'b0 || bus.bypass_dado !== 32'hABCD0000) begin
            err++; $display("FAIL x0_bypass got=%b/%h exp=0/abcd0000", bus.bypass_valido, bus.bypass_dado);
        end
`endif
        tick();
        idle_inputs();
        chk++;
        if (bus.escrita_valida !== 1'b0 || bus.dado_escrita !== 32'hABCD0000) begin
            err++; $display("FAIL x0 got=%b/%h exp=0/abcd0000", bus.escrita_valida, bus.dado_escrita);
        end
    endtask

    task automatic test_random();
        logic        m_pend;
        logic [4:0]  m_rd_cap;
        logic [1:0]  m_tam_cap;
        logic        m_sem_cap;
        logic [1:0]  m_end_cap;
        logic [31:0] m_dado;
        logic [4:0]  m_rd;
        logic        m_val;
        logic [31:0] src;
        int          bad;
        idle_inputs();
        rst = 1'b1;
        tick();
        m_pend = 1'b0; m_rd_cap = '0; m_tam_cap = '0; m_sem_cap = 1'b0; m_end_cap = '0;
        m_dado = '0; m_rd = '0; m_val = 1'b0;
        bad = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst                = ($urandom_range(0, 63) == 0);
            bus.stall          = ($urandom_range(0, 7) == 0);
            bus.flush          = ($urandom_range(0, 15) == 0);
            bus.entrada_valida = ($urandom_range(0, 3) != 0);
            bus.mem_valido     = ($urandom_range(0, 2) == 0);
            bus.sel_fonte      = 2'($urandom_range(0, 3));
            bus.tamanho_load   = 2'($urandom_range(0, 3));
            bus.load_sem_sinal = 1'($urandom_range(0, 1));
            bus.endereco_baixo = 2'($urandom_range(0, 3));
            bus.dado_lido_mem  = $urandom;
            bus.resultado_ula  = $urandom;
            bus.pc_mais_4      = $urandom;
            bus.imediato       = $urandom;
            bus.reg_destino_in = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            #1;
            chk++;
            if (bus.pronto !== (!m_pend && !bus.stall)) begin
                err++;
                if (bad < 10) $display("FAIL rnd_pronto cyc=%0d got=%b exp=%b", cyc, bus.pronto, !m_pend && !bus.stall);
                bad++;
            end
            // Reference: what the next edge does, stated as transactions.
            if (rst) begin
                m_pend = 1'b0; m_rd_cap = '0; m_tam_cap = '0; m_sem_cap = 1'b0; m_end_cap = '0;
                m_dado = '0; m_rd = '0; m_val = 1'b0;
            end else if (bus.flush) begin
                m_val = 1'b0; m_pend = 1'b0;
            end else if (bus.stall) begin
                m_val = m_val;
            end else if (m_pend) begin
                if (bus.mem_valido) begin
                    m_dado = ref_ext(bus.dado_lido_mem, m_tam_cap, m_sem_cap, m_end_cap);
                    m_rd   = m_rd_cap;
                    m_val  = (m_rd_cap != 0);
                    m_pend = 1'b0;
                end else begin
                    m_val = 1'b0;
                end
            end else if (bus.entrada_valida) begin
                if (bus.sel_fonte == 2'b01 && !bus.mem_valido) begin
                    m_pend = 1'b1; m_rd_cap = bus.reg_destino_in; m_tam_cap = bus.tamanho_load;
                    m_sem_cap = bus.load_sem_sinal; m_end_cap = bus.endereco_baixo;
                    m_val = 1'b0;
                end else begin
                    case (bus.sel_fonte)
                        2'b00:   src = bus.resultado_ula;
                        2'b01:   src = ref_ext(bus.dado_lido_mem, bus.tamanho_load, bus.load_sem_sinal, bus.endereco_baixo);
                        2'b10:   src = bus.pc_mais_4;
                        default: src = bus.imediato;
                    endcase
                    m_dado = src; m_rd = bus.reg_destino_in; m_val = (bus.reg_destino_in != 0);
                end
            end else begin
                m_val = 1'b0;
            end
`ifdef ESTAGIO_WB_BYPASS_EN
            chk++;
            if (bus.bypass_valido !== m_val || (m_val && (bus.bypass_dado !== m_dado || bus.bypass_reg !== m_rd))) begin
                err++;
                if (bad < 10) $display("FAIL rnd_bypass cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.bypass_valido, bus.bypass_dado, m_val, m_dado);
                bad++;
            end
`endif
            tick();
            chk++;
            if (bus.escrita_valida !== m_val || bus.dado_escrita !== m_dado || bus.reg_destino !== m_rd) begin
                err++;
                if (bad < 10) $display("FAIL rnd_out cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", cyc,
                    bus.escrita_valida, bus.dado_escrita, bus.reg_destino, m_val, m_dado, m_rd);
                bad++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        chk = 0;
        err = 0;
        idle_inputs();
        #2;
        test_reset();
        test_ula();
        test_reset_mid_wait();
        test_signed_byte();
        test_half_wait();
        test_stall_flush();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
